// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and constants for the I2C target receiver
//
// Purpose : state encoding, field widths and the R/W bit encoding used by
//           i2c_slave_rx and its helpers.
// Contents: I2C_ADDR_W, I2C_BYTE_W, I2C_WRITE, i2c_state_e.
package i2c_pkg;

    localparam int   I2C_ADDR_W = 7;
    localparam int   I2C_BYTE_W = 8;
    localparam logic I2C_WRITE  = 1'b0;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        DATA     = 3'd3,
        DATA_ACK = 3'd4,
        IGNORE   = 3'd5
    } i2c_state_e;

endpackage

// File: rtl/i2c_sync_edge.sv
// rtl/i2c_sync_edge.sv - N-stage input synchroniser with rise/fall strobes
//
// Purpose : brings an asynchronous bus line into the clk domain and flags
//           its edges. All stages reset to 1 so an idle bus reads as idle.
// Ports   : clk, rst_n (async, active-low), din (raw line)
//           dout (synchronised line), rise/fall (one-cycle edge strobes)
module i2c_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign dout = sync_q[STAGES-1];
    assign rise = dout & ~prev_q;
    assign fall = ~dout & prev_q;

endmodule

// File: rtl/i2c_slave_rx.sv
// rtl/i2c_slave_rx.sv - write-only I2C target receiver
//
// Purpose : oversamples SCL/SDA, detects START/STOP, matches a 7-bit
//           address, drives ACK and strobes out each received data byte.
// Ports   : clk, reset_n (async, active-low)
//           scl, sda_in   - bus lines as seen on the wire
//           sda_oe        - 1 pulls SDA low (open-drain)
//           rx_data/rx_valid - received byte and its one-cycle strobe
//           addr_hit      - addressed as write target, until STOP/START
//           stop_seen     - one-cycle strobe on STOP
//           busy          - between START and STOP
module i2c_slave_rx
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h50,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  scl,
    input  logic                  sda_in,
    output logic                  sda_oe,
    output logic [I2C_BYTE_W-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  addr_hit,
    output logic                  stop_seen,
    output logic                  busy
);

    logic scl_s, scl_rise, scl_fall;
    logic sda_s, sda_rise, sda_fall;

    i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_scl_sync (
        .clk  (clk),
        .rst_n(reset_n),
        .din  (scl),
        .dout (scl_s),
        .rise (scl_rise),
        .fall (scl_fall)
    );

    i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda_sync (
        .clk  (clk),
        .rst_n(reset_n),
        .din  (sda_in),
        .dout (sda_s),
        .rise (sda_rise),
        .fall (sda_fall)
    );

    // Both lines go through identical synchroniser depths, so scl_s is
    // aligned with the SDA edge strobes.
    logic start_det, stop_det;
    assign start_det = sda_fall & scl_s;
    assign stop_det  = sda_rise & scl_s;

    i2c_state_e            state_q, state_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [I2C_BYTE_W-2:0] shift_q, shift_d;
    logic [I2C_BYTE_W-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  addr_hit_q, addr_hit_d;
    logic                  stop_seen_q, stop_seen_d;
    logic                  busy_q, busy_d;
    logic                  sda_oe_q, sda_oe_d;

    // Byte as it stands once the current bit is shifted in.
    logic [I2C_BYTE_W-1:0] byte_in;
    assign byte_in = {shift_q, sda_s};

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        addr_hit_d  = addr_hit_q;
        stop_seen_d = 1'b0;
        busy_d      = busy_q;
        sda_oe_d    = sda_oe_q;

        if (stop_det) begin
            // Partial byte is simply abandoned: no strobe.
            state_d     = IDLE;
            bit_cnt_d   = 3'd0;
            stop_seen_d = 1'b1;
            busy_d      = 1'b0;
            addr_hit_d  = 1'b0;
            sda_oe_d    = 1'b0;
        end else if (start_det) begin
            state_d    = ADDR;
            bit_cnt_d  = 3'd0;
            addr_hit_d = 1'b0;
            sda_oe_d   = 1'b0;
            busy_d     = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                end
                ADDR: begin
                    if (scl_rise) begin
                        shift_d   = byte_in[I2C_BYTE_W-2:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (byte_in[I2C_BYTE_W-1:1] == SLAVE_ADDR &&
                                byte_in[0] == I2C_WRITE) begin
                                state_d = ADDR_ACK;
                            end else begin
                                state_d = IGNORE;
                            end
                        end
                    end
                end
                ADDR_ACK, DATA_ACK: begin
                    // First SCL fall after the 8th bit opens the ACK window,
                    // the next one closes it; SCL is low at both points.
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d  = 1'b0;
                            state_d   = DATA;
                            bit_cnt_d = 3'd0;
                            if (state_q == ADDR_ACK) begin
                                addr_hit_d = 1'b1;
                            end
                        end
                    end
                end
                DATA: begin
                    if (scl_rise) begin
                        shift_d   = byte_in[I2C_BYTE_W-2:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_d  = byte_in;
                            rx_valid_d = 1'b1;
                            state_d    = DATA_ACK;
                        end
                    end
                end
                IGNORE: begin
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            addr_hit_q  <= 1'b0;
            stop_seen_q <= 1'b0;
            busy_q      <= 1'b0;
            sda_oe_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            addr_hit_q  <= addr_hit_d;
            stop_seen_q <= stop_seen_d;
            busy_q      <= busy_d;
            sda_oe_q    <= sda_oe_d;
        end
    end

    assign sda_oe    = sda_oe_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign addr_hit  = addr_hit_q;
    assign stop_seen = stop_seen_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// tb/tb_i2c_slave_rx.sv - directed bench for i2c_slave_rx
module tb_i2c_slave_rx;

    localparam int H = 10;

    logic       clk;
    logic       reset_n;
    logic       m_scl;
    logic       m_sda;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       addr_hit;
    logic       stop_seen;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    assign sda_in = m_sda & ~sda_oe;

    i2c_slave_rx #(
        .SLAVE_ADDR (7'h50),
        .SYNC_STAGES(2)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .scl      (m_scl),
        .sda_in   (sda_in),
        .sda_oe   (sda_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .addr_hit (addr_hit),
        .stop_seen(stop_seen),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         rx_cnt      = 0;
    logic [7:0] rx_log [0:63];
    int         stop_cnt    = 0;
    int         oe_rise_cnt = 0;
    logic       oe_prev     = 1'b0;

    always @(negedge clk) begin
        if (rx_valid) begin
            rx_log[rx_cnt & 63] <= rx_data;
            rx_cnt <= rx_cnt + 1;
        end
        if (stop_seen) stop_cnt <= stop_cnt + 1;
        if (sda_oe && !oe_prev) oe_rise_cnt <= oe_rise_cnt + 1;
        oe_prev <= sda_oe;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; wait_clks(H);
        m_scl = 1'b1; wait_clks(H);
        m_sda = 1'b0; wait_clks(H);
        m_scl = 1'b0; wait_clks(5);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wait_clks(H);
        m_scl = 1'b1; wait_clks(H);
        m_sda = 1'b1; wait_clks(H);
    endtask

    task automatic send_bit(input logic b);
        m_sda = b;    wait_clks(H);
        m_scl = 1'b1; wait_clks(H);
        m_scl = 1'b0; wait_clks(5);
    endtask

    task automatic xfer_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        m_sda = 1'b1; wait_clks(H);
        m_scl = 1'b1; wait_clks(H / 2);
        ack = ~sda_in;
        wait_clks(H / 2);
        m_scl = 1'b0; wait_clks(5);
    endtask

    initial begin
        logic ack;
        int   rx_b, st_b, oe_b;

        reset_n = 1'b0;
        m_scl   = 1'b1;
        m_sda   = 1'b1;
        wait_clks(4);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_addr_hit", addr_hit, 0);
        check("rst_stop_seen", stop_seen, 0);
        check("rst_busy", busy, 0);
        reset_n = 1'b1;
        wait_clks(5);

        // Write 0x50: 0xA5, 0x3C, STOP
        rx_b = rx_cnt; st_b = stop_cnt; oe_b = oe_rise_cnt;
        i2c_start();
        check("t1_busy", busy, 1);
        xfer_byte(8'hA0, ack);
        check("t1_addr_ack", ack, 1);
        check("t1_addr_hit", addr_hit, 1);
        xfer_byte(8'hA5, ack);
        check("t1_d0_ack", ack, 1);
        xfer_byte(8'h3C, ack);
        check("t1_d1_ack", ack, 1);
        check("t1_hit_before_stop", addr_hit, 1);
        i2c_stop();
        wait_clks(5);
        check("t1_rx_cnt", rx_cnt - rx_b, 2);
        check("t1_rx0", rx_log[rx_b & 63], 8'hA5);
        check("t1_rx1", rx_log[(rx_b + 1) & 63], 8'h3C);
        check("t1_ack_slots", oe_rise_cnt - oe_b, 3);
        check("t1_stop_cnt", stop_cnt - st_b, 1);
        check("t1_busy_after", busy, 0);
        check("t1_hit_after", addr_hit, 0);

        // Write to 0x51: ignored
        rx_b = rx_cnt; st_b = stop_cnt; oe_b = oe_rise_cnt;
        i2c_start();
        xfer_byte(8'hA2, ack);
        check("t2_addr_nack", ack, 0);
        check("t2_addr_hit", addr_hit, 0);
        check("t2_busy", busy, 1);
        xfer_byte(8'h11, ack);
        check("t2_data_nack", ack, 0);
        i2c_stop();
        wait_clks(5);
        check("t2_no_oe", oe_rise_cnt - oe_b, 0);
        check("t2_no_rx", rx_cnt - rx_b, 0);
        check("t2_busy_after", busy, 0);
        check("t2_stop_cnt", stop_cnt - st_b, 1);

        // Read request to 0x50: ignored for the following 9 clocks
        rx_b = rx_cnt; oe_b = oe_rise_cnt;
        i2c_start();
        xfer_byte(8'hA1, ack);
        check("t3_addr_nack", ack, 0);
        xfer_byte(8'hFF, ack);
        check("t3_9clk_nack", ack, 0);
        check("t3_no_oe", oe_rise_cnt - oe_b, 0);
        check("t3_addr_hit", addr_hit, 0);
        i2c_stop();
        wait_clks(5);
        check("t3_no_rx", rx_cnt - rx_b, 0);

        // Repeated START after 4 bits of 0x5A
        rx_b = rx_cnt;
        i2c_start();
        xfer_byte(8'hA0, ack);
        check("t4_addr_ack", ack, 1);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        i2c_start();
        check("t4_hit_cleared", addr_hit, 0);
        check("t4_busy", busy, 1);
        xfer_byte(8'hA0, ack);
        check("t4_addr2_ack", ack, 1);
        xfer_byte(8'h81, ack);
        check("t4_data_ack", ack, 1);
        i2c_stop();
        wait_clks(5);
        check("t4_rx_cnt", rx_cnt - rx_b, 1);
        check("t4_rx0", rx_log[rx_b & 63], 8'h81);

        // STOP mid-byte, then a normal transfer
        rx_b = rx_cnt; st_b = stop_cnt;
        i2c_start();
        xfer_byte(8'hA0, ack);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        i2c_stop();
        wait_clks(5);
        check("t5_no_rx", rx_cnt - rx_b, 0);
        check("t5_stop_cnt", stop_cnt - st_b, 1);
        check("t5_busy", busy, 0);
        i2c_start();
        xfer_byte(8'hA0, ack);
        check("t5_addr_ack", ack, 1);
        xfer_byte(8'hC3, ack);
        i2c_stop();
        wait_clks(5);
        check("t5_rx_cnt", rx_cnt - rx_b, 1);
        check("t5_rx0", rx_log[rx_b & 63], 8'hC3);

        // Reset during the data ACK
        i2c_start();
        xfer_byte(8'hA0, ack);
        for (int i = 7; i >= 0; i--) send_bit(1'(8'h77 >> i));
        m_sda = 1'b1;
        wait_clks(H);
        check("t6_ack_driven", sda_oe, 1);
        reset_n = 1'b0;
        #1;
        check("t6_async_release", sda_oe, 0);
        wait_clks(3);
        check("t6_rx_data", rx_data, 8'h00);
        check("t6_rx_valid", rx_valid, 0);
        check("t6_addr_hit", addr_hit, 0);
        check("t6_stop_seen", stop_seen, 0);
        check("t6_busy", busy, 0);
        reset_n = 1'b1;
        wait_clks(3);
        i2c_stop();
        wait_clks(5);
        rx_b = rx_cnt;
        i2c_start();
        xfer_byte(8'hA0, ack);
        check("t6_addr_ack", ack, 1);
        xfer_byte(8'h99, ack);
        check("t6_data_ack", ack, 1);
        i2c_stop();
        wait_clks(5);
        check("t6_rx_cnt", rx_cnt - rx_b, 1);
        check("t6_rx0", rx_log[rx_b & 63], 8'h99);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
